// File: rtl/boot_loader_pkg.sv
// Shared constants and state encodings for the UART program loader.
// Frame layout: START_BYTE, length (2 bytes, big-endian), data words, checksum byte.
package boot_loader_pkg;
  localparam logic [7:0] START_BYTE     = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchronizer, mid-bit sampling, stop-bit framing check.
// Outputs a one-cycle byte_valid or frame_err pulse at the stop-bit sample.
module uart_rx_byte
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // A start needs a true high-to-low edge, so a line held low after a
  // framing error cannot retrigger until it has returned to idle.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    byte_data  = shreg;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = RX_STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n      = '0;
          state_n    = RX_IDLE;
          byte_valid = rx_sync;
          frame_err  = !rx_sync;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/boot_loader_uart.sv
// Serial program loader: parses a framed image from the UART, writes it into
// instruction memory word by word, and releases the core once the checksum matches.
module boot_loader_uart
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              cpu_reset,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);
  localparam int MAX_WORDS = 2 ** ADDR_W;
  localparam int CW        = ADDR_W + 1;

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  state_t              state, state_n;
  logic [7:0]          len_hi, len_hi_n;
  logic [CW-1:0]       len, len_n;
  logic [CW-1:0]       word_cnt, word_cnt_n;
  logic [1:0]          byte_cnt, byte_cnt_n;
  logic [DATA_W-1:0]   word_reg, word_reg_n;
  logic [7:0]          sum, sum_n;
  logic                err_q, err_n;
  logic                we_q, we_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;

  logic [15:0]         len_rx;
  logic [7:0]          sum_next;
  logic [CW-1:0]       word_cnt_inc;
  logic [DATA_W-1:0]   word_shifted;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign len_rx       = {len_hi, byte_data};
  assign sum_next     = sum + byte_data;
  assign word_cnt_inc = word_cnt + CW'(1);
  assign word_shifted = {word_reg[DATA_W-9:0], byte_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_hi   <= '0;
      len      <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      word_reg <= '0;
      sum      <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_n;
      len_hi   <= len_hi_n;
      len      <= len_n;
      word_cnt <= word_cnt_n;
      byte_cnt <= byte_cnt_n;
      word_reg <= word_reg_n;
      sum      <= sum_n;
      err_q    <= err_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
    end
  end

  always_comb begin
    state_n    = state;
    len_hi_n   = len_hi;
    len_n      = len;
    word_cnt_n = word_cnt;
    byte_cnt_n = byte_cnt;
    word_reg_n = word_reg;
    sum_n      = sum;
    err_n      = err_q;
    we_n       = 1'b0;
    addr_n     = addr_q;
    wdata_n    = wdata_q;
    if (frame_err && state != IDLE && state != RUN) begin
      err_n   = 1'b1;
      state_n = IDLE;
    end else if (byte_valid) begin
      case (state)
        IDLE: begin
          if (byte_data == START_BYTE) begin
            err_n      = 1'b0;
            sum_n      = '0;
            word_cnt_n = '0;
            byte_cnt_n = '0;
            state_n    = LEN_HI;
          end
        end
        LEN_HI: begin
          len_hi_n = byte_data;
          state_n  = LEN_LO;
        end
        LEN_LO: begin
          len_n = CW'(len_rx);
          if (len_rx > 16'(MAX_WORDS)) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else if (len_rx == 16'd0) begin
            state_n = CHK;
          end else begin
            state_n = DATA;
          end
        end
        DATA: begin
          word_reg_n = word_shifted;
          sum_n      = sum_next;
          byte_cnt_n = byte_cnt + 2'd1;
          // Last byte of a word: commit the assembled word on the next cycle.
          if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
            we_n       = 1'b1;
            addr_n     = word_cnt[ADDR_W-1:0];
            wdata_n    = word_shifted;
            word_cnt_n = word_cnt_inc;
            if (word_cnt_inc == len) state_n = CHK;
          end
        end
        CHK: begin
          if (sum_next == 8'd0) begin
            state_n = RUN;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
        RUN:     state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  assign cpu_reset  = (state != RUN);
  assign done       = (state == RUN);
  assign err        = err_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign dbg_state  = state;
endmodule
